// File: rtl/addsub_seq_pkg.sv
// rtl/addsub_seq_pkg.sv - shared FSM state type and step-count helpers for addsub_seq
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int DIGIT_DEF = 1;
  localparam int STEPS     = WIDTH_DEF / DIGIT_DEF;
  localparam int CNT_W     = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Parameterised forms used by the top so other WIDTH/DIGIT pairs size correctly
  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_bits(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - one-bit full adder
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - digit-serial adder/subtractor, DIGIT bits per cycle, LSB first
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int n_steps = steps_of(WIDTH, DIGIT);
  localparam int cnt_w   = cnt_bits(n_steps);

  state_t             state, next_state;
  logic [cnt_w-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [WIDTH-1:0]   result_r;
  logic               carry_r, ovf_r;
  logic               accept, last_step;
  logic [DIGIT:0]     c;
  logic [DIGIT-1:0]   s;
  logic [WIDTH+DIGIT-1:0] shifted;

  assign last_step = (cnt == cnt_w'(n_steps - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Ripple chain for one digit; c[DIGIT-1] is the carry into the slice's top bit
  assign c[0] = carry_r;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    adder u_fa (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .carry(c[i+1])
    );
  end

  assign shifted = {s, result_r};

  // Subtraction folds into the latch: store ~b and preset the carry to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= sub ? ~b : b;
      carry_r <= sub;
      ovf_r   <= 1'b0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh     <= a_sh >> DIGIT;
      b_sh     <= b_sh >> DIGIT;
      result_r <= shifted[WIDTH+DIGIT-1:DIGIT];
      carry_r  <= c[DIGIT];
      cnt      <= cnt + cnt_w'(1);
      if (last_step) ovf_r <= c[DIGIT] ^ c[DIGIT-1];
    end
  end

  assign result   = result_r;
  assign carry    = carry_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - self-checking bench for addsub_seq (DIGIT=1 and DIGIT=4 instances)
module tb_addsub_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0;
  logic       busy1, done1, carry1, ovf1;
  logic       busy4, done4, carry4, ovf4;
  logic [7:0] res1, res4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .sub(sub),
    .busy(busy1), .done(done1), .result(res1), .carry(carry1), .overflow(ovf1)
  );

  addsub_seq #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .sub(sub),
    .busy(busy4), .done(done4), .result(res4), .carry(carry4), .overflow(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       car;
    logic       ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s,
                                output logic [7:0] r, output logic c, output logic v);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    if (s) begin
      ur = ux - uy; sr = sx - sy; c = (ux >= uy);
    end else begin
      ur = ux + uy; sr = sx + sy; c = (ur > 255);
    end
    r = ur[7:0];
    v = (sr > 127) || (sr < -128);
  endfunction

  task automatic pulse_start(input int which);
    if (which == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
  endtask

  // Operands are scrambled every cycle while waiting; the DUT must ignore them
  task automatic wait_done(input int which, input int lat0, output int lat);
    lat = lat0;
    while (((which == 4) ? done4 : done1) !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      lat++;
    end
    if (lat >= 100) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int which, input logic [7:0] x, input logic [7:0] y, input logic s,
                        output int lat);
    a = x; b = y; sub = s;
    pulse_start(which);
    wait_done(which, 1, lat);
  endtask

  task automatic chk_out(input string name, input int which, input logic [7:0] r,
                         input logic c, input logic v);
    if (which == 4) begin
      chk({name, "_res"}, res4, r); chk({name, "_carry"}, carry4, c); chk({name, "_ovf"}, ovf4, v);
    end else begin
      chk({name, "_res"}, res1, r); chk({name, "_carry"}, carry1, c); chk({name, "_ovf"}, ovf1, v);
    end
  endtask

  initial begin
    int lat;
    logic [7:0] er, x, y;
    logic ec, ev, s;
    bit seen;

    vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_res", res1, 0);
    chk("rst_carry", carry1, 0); chk("rst_ovf", ovf1, 0);
    rst = 1'b0;

    // First start after reset is accepted on the next edge
    a = vecs[0].a; b = vecs[0].b; sub = vecs[0].sub;
    pulse_start(1);
    chk("first_accept_busy", busy1, 1);
    wait_done(1, 1, lat);
    chk("lat_digit1", lat, 9);
    chk_out("vec0", 1, vecs[0].res, vecs[0].car, vecs[0].ovf);

    for (int i = 1; i < 6; i++) begin
      run_op(1, vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("vec%0d_lat", i), lat, 9);
      chk_out($sformatf("vec%0d", i), 1, vecs[i].res, vecs[i].car, vecs[i].ovf);
    end

    // Results hold after DONE
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", done1, 0);
    chk_out("hold", 1, vecs[5].res, vecs[5].car, vecs[5].ovf);

    // DIGIT=4 instance
    run_op(4, 8'h3C, 8'h0F, 1'b0, lat);
    chk("d4_lat", lat, 3);
    chk_out("d4_3c0f", 4, 8'h4B, 1'b0, 1'b0);

    // start in 3rd RUN cycle is ignored
    a = 8'h11; b = 8'h22; sub = 1'b0;
    pulse_start(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'hBB; sub = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1, 4, lat);
    chk("ignore_lat", lat, 9);
    chk_out("ignore", 1, 8'h33, 1'b0, 1'b0);

    // start in DONE cycle runs back-to-back
    a = 8'h40; b = 8'h05; sub = 1'b1;
    pulse_start(1);
    chk("b2b_busy", busy1, 1); chk("b2b_done", done1, 0);
    wait_done(1, 1, lat);
    chk("b2b_lat", lat, 9);
    chk_out("b2b", 1, 8'h3B, 1'b1, 1'b0);

    // Reset in the 4th RUN cycle
    a = 8'hFF; b = 8'h00; sub = 1'b0;
    pulse_start(1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy1, 0); chk("midrst_done", done1, 0); chk("midrst_res", res1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done1 === 1'b1) seen = 1'b1; end
    chk("midrst_no_done", seen, 0);

    // Randomised against the reference model
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      if (i == 0) begin x = 8'h80; y = 8'h80; s = 1'b0; end
      model(x, y, s, er, ec, ev);
      run_op(1, x, y, s, lat);
      chk($sformatf("rnd1_%0d_lat", i), lat, 9);
      chk_out($sformatf("rnd1_%0d", i), 1, er, ec, ev);
    end
    for (int i = 0; i < 25; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      model(x, y, s, er, ec, ev);
      run_op(4, x, y, s, lat);
      chk($sformatf("rnd4_%0d_lat", i), lat, 3);
      chk_out($sformatf("rnd4_%0d", i), 4, er, ec, ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, meaning bits processed per cycle; legal values divide WIDTH exactly.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port start  input  1  request; operands sampled on the accepting edge.
REQ-007 Port a  input  WIDTH  first operand.
REQ-008 Port b  input  WIDTH  second operand.
REQ-009 Port sub  input  1  0 = a+b, 1 = a-b; sampled with operands.
REQ-010 Port busy  output  1  high while an operation is in progress.
REQ-011 Port done  output  1  single-cycle pulse; result, carry and overflow valid.
REQ-012 Port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 Port carry  output  1  adder carry-out; for subtraction 1 = no borrow (a >= b unsigned).
REQ-014 Port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b and sub, preset the carry register to sub, clear the step counter and enter RUN.
REQ-017 When sub=1, the block SHALL add the bitwise inverse of b, with carry-in 1 (two's complement).
REQ-018 Each RUN cycle SHALL add DIGIT bits LSB-first, using the stored carry as carry-in, and shift the DIGIT sum bits into result from the MSB end.
REQ-019 After WIDTH/DIGIT RUN cycles, the FSM SHALL enter DONE for exactly one cycle, then IDLE unless start is accepted.
REQ-020 Latency: if start is accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH/DIGIT.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 start SHALL be ignored while busy=1; in-flight operands SHALL be unaffected.
REQ-023 result, carry and overflow SHALL hold their values from DONE until the next accepted start.
REQ-024 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-025 Operand changes on a and b outside the accepting edge SHALL have no effect.

Reset
REQ-026 On rst=1, the FSM SHALL go to IDLE immediately; busy, done, result, carry and overflow SHALL be 0 and the counter cleared, including mid-operation.
REQ-027 After rst deasserts, the first start SHALL be accepted on the next rising clk.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the localparam STEPS = WIDTH/DIGIT with its counter width.
REQ-029 The DIGIT-bit slice SHALL be built from DIGIT instances of the existing one-bit full adder, adder (a, b, cin -> sum, carry), rippled in a chain.
REQ-030 The implementation SHALL contain no other sub-module.

Verification
REQ-031 With WIDTH=8, DIGIT=1, sub=0, a=0x7F, b=0x01: the bench SHALL see done 9 cycles after start, with result=0x80, carry=0 and overflow=1.
REQ-032 With WIDTH=8, sub=1, a=0x05, b=0x07: the bench SHALL see result=0xFE, carry=0 and overflow=0; with a=0x07, b=0x05, it SHALL see result=0x02 and carry=1.
REQ-033 With WIDTH=8, sub=0, a=0xFF, b=0x01: the bench SHALL see result=0x00, carry=1 and overflow=0.
REQ-034 A start pulse with new operands in the 3rd RUN cycle SHALL leave the result of the first operation unchanged; a start in the DONE cycle SHALL begin a new operation back-to-back.
REQ-035 rst asserted in the 4th RUN cycle SHALL make busy=0, done=0 and result=0 at once, and no done pulse SHALL follow.
REQ-036 With WIDTH=8, DIGIT=4, 0x3C+0x0F: the bench SHALL see done 3 cycles after start, with result=0x4B, carry=0 and overflow=0.
